// File: rtl/ga_req_arbiter.sv
// Round-robin arbiter that lets NumReq requesters share a single GA coprocessor.
// Only one transaction is in flight at a time. It passes through
// IDLE -> ISSUE -> WAIT -> RESP, and WAIT is bounded by a response timeout.
module ga_req_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned PayloadW      = 64,
  parameter int unsigned RespW         = 32,
  parameter int unsigned TimeoutCycles = 64,
  localparam int unsigned IdW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*PayloadW-1:0]   req_data_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  input  logic [NumReq-1:0]            rsp_ready_i,
  output logic [RespW-1:0]             rsp_data_o,
  output logic                         rsp_error_o,
  output logic                         co_req_valid_o,
  input  logic                         co_req_ready_i,
  output logic [PayloadW-1:0]          co_req_data_o,
  input  logic                         co_resp_valid_i,
  input  logic                         co_resp_error_i,
  input  logic [RespW-1:0]             co_resp_data_i,
  output logic                         busy_o,
  output logic [IdW-1:0]               grant_id_o,
  output logic                         timeout_o
);

  localparam int unsigned TmrW = $clog2(TimeoutCycles) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              r_state,   w_state_d;
  logic [IdW-1:0]      r_rr_ptr,  w_rr_ptr_d;
  logic [IdW-1:0]      r_id,      w_id_d;
  logic [PayloadW-1:0] r_payload, w_payload_d;
  logic [TmrW-1:0]     r_timer,   w_timer_d;
  logic [RespW-1:0]    r_data,    w_data_d;
  logic                r_error,   w_error_d;
  logic                r_timeout, w_timeout_d;

  logic                w_found;
  logic [IdW-1:0]      w_winner;

  // Round-robin search that starts just above the last winner and wraps around.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int i = 1; i <= int'(NumReq); i++) begin
      idx = (int'(r_rr_ptr) + i) % int'(NumReq);
      if (!w_found && req_valid_i[idx]) begin
        w_found  = 1'b1;
        w_winner = IdW'(idx);
      end
    end
  end

  // Next-state and datapath update for the transaction FSM.
  always_comb begin
    w_state_d   = r_state;
    w_rr_ptr_d  = r_rr_ptr;
    w_id_d      = r_id;
    w_payload_d = r_payload;
    w_timer_d   = r_timer;
    w_data_d    = r_data;
    w_error_d   = r_error;
    w_timeout_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_rr_ptr_d  = w_winner;
          w_id_d      = w_winner;
          w_payload_d = req_data_i[int'(w_winner)*PayloadW +: PayloadW];
          w_state_d   = StIssue;
        end
      end
      StIssue: begin
        if (co_req_ready_i) begin
          w_timer_d = '0;
          w_state_d = StWait;
        end
      end
      StWait: begin
        w_timer_d = r_timer + 1'b1;
        // A response that arrives in the timeout cycle wins over the timeout.
        if (co_resp_valid_i) begin
          w_data_d  = co_resp_data_i;
          w_error_d = co_resp_error_i;
          w_state_d = StResp;
        end else if (r_timer == TmrW'(TimeoutCycles - 1)) begin
          w_data_d    = '0;
          w_error_d   = 1'b1;
          w_timeout_d = 1'b1;
          w_state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i[r_id]) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset drops any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_rr_ptr  <= IdW'(NumReq - 1);
      r_id      <= '0;
      r_payload <= '0;
      r_timer   <= '0;
      r_data    <= '0;
      r_error   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_rr_ptr  <= w_rr_ptr_d;
      r_id      <= w_id_d;
      r_payload <= w_payload_d;
      r_timer   <= w_timer_d;
      r_data    <= w_data_d;
      r_error   <= w_error_d;
      r_timeout <= w_timeout_d;
    end
  end

  // Outputs are decoded from the state, so each one is zero outside its own state.
  always_comb begin
    req_ready_o    = '0;
    rsp_valid_o    = '0;
    rsp_data_o     = '0;
    rsp_error_o    = 1'b0;
    co_req_valid_o = 1'b0;
    co_req_data_o  = '0;
    grant_id_o     = '0;
    busy_o         = (r_state != StIdle);
    timeout_o      = r_timeout;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          req_ready_o[w_winner] = 1'b1;
        end
      end
      StIssue: begin
        co_req_valid_o = 1'b1;
        co_req_data_o  = r_payload;
        grant_id_o     = r_id;
      end
      StWait: begin
        grant_id_o = r_id;
      end
      StResp: begin
        rsp_valid_o[r_id] = 1'b1;
        rsp_data_o        = r_data;
        rsp_error_o       = r_error;
        grant_id_o        = r_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ga_req_arbiter.sv
// Self-checking bench for ga_req_arbiter. The bench plays the coprocessor and
// queues the response it expects for each grant.
module tb_ga_req_arbiter;

  localparam int unsigned NumReq        = 4;
  localparam int unsigned PayloadW      = 64;
  localparam int unsigned RespW         = 32;
  localparam int unsigned TimeoutCycles = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NumReq-1:0]          req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NumReq*PayloadW-1:0] req_data;
  logic [RespW-1:0]           rsp_data, co_resp_data;
  logic                       rsp_error, co_req_valid, co_req_ready;
  logic [PayloadW-1:0]        co_req_data;
  logic                       co_resp_valid, co_resp_error, busy, timeout;
  logic [1:0]                 grant_id;

  ga_req_arbiter #(
    .NumReq        (NumReq),
    .PayloadW      (PayloadW),
    .RespW         (RespW),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_data_i      (req_data),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_error_o     (rsp_error),
    .co_req_valid_o  (co_req_valid),
    .co_req_ready_i  (co_req_ready),
    .co_req_data_o   (co_req_data),
    .co_resp_valid_i (co_resp_valid),
    .co_resp_error_i (co_resp_error),
    .co_resp_data_i  (co_resp_data),
    .busy_o          (busy),
    .grant_id_o      (grant_id),
    .timeout_o       (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   model_ptr;
  int   txn_cnt  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_data, rsp_error, co_req_valid, co_req_data,
              busy, grant_id, timeout}, 128'(0));
  endtask

  task automatic set_payloads();
    for (int k = 0; k < int'(NumReq); k++) begin
      req_data[k*PayloadW +: PayloadW] = {32'hA000_0000 | 32'(k), 32'(txn_cnt)};
    end
    txn_cnt++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    model_ptr = NumReq - 1;
    chk_all_zero("reset_zero");
  endtask

  // One transaction. rsp_dly < 0 means the coprocessor never answers.
  task automatic txn(input int co_rdy_dly, input int rsp_dly, input int rsp_hold,
                     input logic [31:0] rdata, input logic rerr, input int rsp_rdy_dly,
                     input bit abort_wait, input bit drop, output int gid);
    int            exp_id;
    int            wait_n;
    logic [63:0]   exp_pay;
    logic [3:0]    oh;
    rsp_t          e;
    bit            tmo;
    gid = -1;
    tmo = (rsp_dly < 0);
    #1;
    wait_n = 0;
    while (req_ready == '0 && wait_n < 20) begin
      step();
      #1;
      wait_n++;
    end
    if (req_ready == '0) begin
      chk("grant_wait", 128'(0), 128'(1));
      return;
    end
    exp_id = -1;
    for (int i = 1; i <= int'(NumReq); i++) begin
      int k;
      k = (model_ptr + i) % int'(NumReq);
      if (req_valid[k] && exp_id < 0) exp_id = k;
    end
    if (exp_id < 0) exp_id = 0;
    oh = 4'(1) << exp_id;
    chk("grant", 128'(req_ready), 128'(oh));
    gid       = exp_id;
    model_ptr = exp_id;
    exp_pay   = req_data[exp_id*PayloadW +: PayloadW];
    e.id      = 2'(exp_id);
    e.data    = tmo ? 32'h0 : rdata;
    e.err     = tmo ? 1'b1 : rerr;
    sb_q.push_back(e);
    step();
    // Disturb the source payload so only the latched copy is correct.
    req_data[exp_id*PayloadW +: PayloadW] = ~exp_pay;
    if (drop) req_valid[exp_id] = 1'b0;
    // ISSUE
    for (int c = 0; c < co_rdy_dly; c++) begin
      co_req_ready = 1'b0;
      #1;
      chk("co_valid_hold", 128'(co_req_valid), 128'(1));
      chk("co_data_hold", 128'(co_req_data), 128'(exp_pay));
      chk("issue_no_tmo", 128'(timeout), 128'(0));
      step();
    end
    co_req_ready = 1'b1;
    #1;
    chk("co_valid", 128'(co_req_valid), 128'(1));
    chk("co_data", 128'(co_req_data), 128'(exp_pay));
    chk("issue_gid_busy_rdy", {busy, grant_id, req_ready}, {1'b1, 2'(exp_id), 4'b0});
    step();
    co_req_ready = 1'b0;
    // WAIT
    if (abort_wait) begin
      #1;
      chk("wait_busy", {busy, grant_id}, {1'b1, 2'(exp_id)});
      void'(sb_q.pop_back());
      rst       = 1'b1;
      req_valid = '0;
      step();
      rst = 1'b0;
      #1;
      model_ptr = NumReq - 1;
      chk_all_zero("abort_zero");
      return;
    end
    if (tmo) begin
      for (int c = 0; c < int'(TimeoutCycles); c++) begin
        #1;
        chk("wait_quiet", {rsp_valid, timeout}, 128'(0));
        step();
      end
    end else begin
      for (int c = 0; c < rsp_dly; c++) begin
        #1;
        chk("wait_quiet", {rsp_valid, timeout}, 128'(0));
        step();
      end
      co_resp_valid = 1'b1;
      co_resp_data  = rdata;
      co_resp_error = rerr;
      step();
      // A held second valid cycle carries different data that must be ignored.
      if (rsp_hold > 1) begin
        co_resp_data  = ~rdata;
        co_resp_error = ~rerr;
      end else begin
        co_resp_valid = 1'b0;
      end
    end
    // RESP
    e = sb_q.pop_front();
    oh = 4'(1) << e.id;
    for (int c = 0; c <= rsp_rdy_dly; c++) begin
      rsp_ready = (c == rsp_rdy_dly) ? oh : ~oh;
      #1;
      chk("rsp_valid", 128'(rsp_valid), 128'(oh));
      chk("rsp_data", 128'(rsp_data), 128'(e.data));
      chk("rsp_error", 128'(rsp_error), 128'(e.err));
      chk("rsp_gid", 128'(grant_id), 128'(e.id));
      chk("tmo_pulse", 128'(timeout), 128'(tmo && c == 0));
      step();
      co_resp_valid = 1'b0;
    end
    rsp_ready = '0;
    #1;
    chk("after_rsp", {rsp_valid, rsp_data, rsp_error, timeout}, 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid;
    rst           = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    rsp_ready     = '0;
    co_req_ready  = 1'b0;
    co_resp_valid = 1'b0;
    co_resp_error = 1'b0;
    co_resp_data  = '0;
    do_reset();

    // Requesters 0 and 2 together: 0 then 2, leaving the pointer at 2.
    set_payloads();
    req_valid = 4'b0101;
    txn(0, 0, 1, 32'h1111_0000, 1'b0, 0, 1'b0, 1'b1, gid);
    chk("first_grant", 128'(gid), 128'(0));
    set_payloads();
    txn(1, 1, 1, 32'h2222_0000, 1'b0, 0, 1'b0, 1'b1, gid);
    chk("second_grant", 128'(gid), 128'(2));
    req_valid = '0;
    set_payloads();
    req_valid = 4'b1011;
    txn(0, 0, 1, 32'h3333_0000, 1'b0, 0, 1'b0, 1'b1, gid);
    chk("after_ptr2", 128'(gid), 128'(3));
    req_valid = '0;

    // Four requesters asserted continuously.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      set_payloads();
      txn(i % 2, i % 3, 1, 32'(i) * 32'h0101_0101, 1'(i % 2), i % 2, 1'b0, 1'b0, gid);
      chk("rr_order", 128'(gid), 128'(i % 4));
    end
    req_valid = '0;

    // Held coprocessor valid yields exactly one response.
    set_payloads();
    req_data[1*PayloadW +: PayloadW] = 64'h1234;
    req_valid = 4'b0010;
    txn(0, 0, 2, 32'hABCD, 1'b0, 0, 1'b0, 1'b1, gid);
    chk("hold_gid", 128'(gid), 128'(1));
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk("no_dup_rsp", {rsp_valid, busy}, 128'(0));
    end

    // Coprocessor silent: timeout with error and zero data.
    set_payloads();
    req_valid = 4'b0100;
    txn(0, -1, 1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 1'b1, gid);

    // Response in the timeout cycle itself takes precedence.
    set_payloads();
    req_valid = 4'b0001;
    txn(0, int'(TimeoutCycles) - 1, 1, 32'h5555, 1'b1, 1, 1'b0, 1'b1, gid);

    // Coprocessor slow to accept; ISSUE has no timeout.
    set_payloads();
    req_valid = 4'b1000;
    txn(5, 3, 1, 32'h7777_8888, 1'b0, 0, 1'b0, 1'b1, gid);

    // Slow response consumer, then reset in the middle of WAIT.
    set_payloads();
    req_valid = 4'b0010;
    txn(0, 2, 1, 32'h0BAD_F00D, 1'b0, 3, 1'b0, 1'b1, gid);
    set_payloads();
    req_valid = 4'b0001;
    txn(0, 0, 1, 32'h0, 1'b0, 0, 1'b1, 1'b1, gid);
    for (int c = 0; c < int'(TimeoutCycles) + 2; c++) begin
      step();
      #1;
      chk_all_zero("post_abort_quiet");
    end
    set_payloads();
    req_valid = 4'b0011;
    txn(0, 1, 1, 32'h4242_4242, 1'b0, 0, 1'b0, 1'b1, gid);
    chk("post_reset_grant", 128'(gid), 128'(0));
    req_valid = '0;

    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
